// File: rtl/ldo_test_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the LDO serial test-access port.
// The optional parity mode is enabled by defining LDO_TEST_PARITY_EN.
package ldo_test_pkg;

  localparam int LDO_DATA_W = 32;
  localparam int LDO_CMD_W  = 2;

  localparam logic [LDO_CMD_W-1:0] OP_NOP   = 2'b00;
  localparam logic [LDO_CMD_W-1:0] OP_WRITE = 2'b01;
  localparam logic [LDO_CMD_W-1:0] OP_READ  = 2'b10;
  localparam logic [LDO_CMD_W-1:0] OP_MODE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } st_e;

endpackage

// File: rtl/ldo_test_port_if.sv
// Chip-level serial pins of the LDO test-access port.
// The host drives frame/shift/data; the port returns serial data and busy.
interface ldo_test_port_if;

  logic frame_i;
  logic shift_en_i;
  logic sdi_i;
  logic sdo_o;
  logic busy_o;

  modport master (
    output frame_i,
    output shift_en_i,
    output sdi_i,
    input  sdo_o,
    input  busy_o
  );

  modport slave (
    input  frame_i,
    input  shift_en_i,
    input  sdi_i,
    output sdo_o,
    output busy_o
  );

endinterface

// File: rtl/ldo_test_sreg.sv
// Parallel-load, serial-in shift register (MSB leaves first) shared by the
// command and data phases of a test frame.
module ldo_test_sreg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              sh,
  input  logic              sin,
  output logic [DATA_W-1:0] q
);

  // A load wins over a shift so a read capture is never corrupted by the last command bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_data;
    end else if (sh) begin
      q <= {q[DATA_W-2:0], sin};
    end
  end

endmodule

// File: rtl/ldo_test_port.sv
// Serial test-access port driving the LDO pass-gate test word and test-mode select,
// with readback of the live pass-gate code. Define LDO_TEST_PARITY_EN for the parity bit and err_o.
module ldo_test_port
  import ldo_test_pkg::*;
#(
  parameter int   DATA_W      = LDO_DATA_W,
  parameter int   CMD_W       = LDO_CMD_W,
  parameter logic TEST_EN_RST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  ldo_test_port_if.slave    sp,
  input  logic [DATA_W-1:0] code_i,
  output logic              test_en_o,
  output logic [DATA_W-1:0] test_word_o,
`ifdef LDO_TEST_PARITY_EN
  output logic              err_o,
`endif
  output logic              upd_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
`ifdef LDO_TEST_PARITY_EN
  localparam int LAST_IDX = DATA_W;
`else
  localparam int LAST_IDX = DATA_W - 1;
`endif

  typedef logic [CNT_W-1:0] cnt_t;

  st_e               st_q, st_nxt;
  cnt_t              cnt_q;
  logic [CMD_W-1:0]  op_q, op_new;
  logic              sdo_q, sdo_nxt;
  logic              busy_q;
  logic              test_en_q;
  logic [DATA_W-1:0] test_word_q;
  logic              upd_q;

  logic              sr_ld, sr_sh, sr_sin;
  logic [DATA_W-1:0] sr_ld_data, sr_q;
  logic              op_lat, cnt_clr, cnt_inc, commit;
  logic              par_ok, wr_commit, md_commit;

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == {CNT_W{1'b1}}) ? c : c + cnt_t'(1);
  endfunction

`ifdef LDO_TEST_PARITY_EN
  logic par_q, rd_par_q, err_q;
  logic bit_take, err_set, err_clr;

  assign bit_take = sp.frame_i & sp.shift_en_i & ((st_q == ST_CMD) | (st_q == ST_DATA));
  assign par_ok   = ~par_q;
  assign err_set  = commit & par_q & ((op_q == OP_WRITE) | (op_q == OP_MODE));
  assign err_clr  = commit & ~par_q & (op_q == OP_NOP);
`else
  assign par_ok = 1'b1;
`endif

  assign op_new    = {sr_q[CMD_W-2:0], sp.sdi_i};
  assign wr_commit = commit & par_ok & (op_q == OP_WRITE);
  assign md_commit = commit & par_ok & (op_q == OP_MODE);

  ldo_test_sreg #(.DATA_W(DATA_W)) u_sreg (
    .clk     (clk),
    .rst     (rst),
    .ld      (sr_ld),
    .ld_data (sr_ld_data),
    .sh      (sr_sh),
    .sin     (sr_sin),
    .q       (sr_q)
  );

  always_comb begin
    st_nxt     = st_q;
    sr_ld      = 1'b0;
    sr_ld_data = '0;
    sr_sh      = 1'b0;
    sr_sin     = sp.sdi_i;
    op_lat     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    commit     = 1'b0;
    sdo_nxt    = sdo_q;
    if (!sp.frame_i) begin
      st_nxt  = ST_IDLE;
      cnt_clr = 1'b1;
      commit  = (st_q == ST_DONE);
      sdo_nxt = 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          st_nxt  = ST_CMD;
          sr_ld   = 1'b1;
          cnt_clr = 1'b1;
          sdo_nxt = 1'b0;
        end
        ST_CMD: begin
          sdo_nxt = 1'b0;
          if (sp.shift_en_i) begin
            if (cnt_q == cnt_t'(CMD_W - 1)) begin
              op_lat  = 1'b1;
              cnt_clr = 1'b1;
              st_nxt  = ST_DATA;
              // Readback captures the live code in the very cycle the opcode is known.
              if (op_new == OP_READ) begin
                sr_ld      = 1'b1;
                sr_ld_data = code_i;
              end else begin
                sr_sh = 1'b1;
              end
            end else begin
              sr_sh   = 1'b1;
              cnt_inc = 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (sp.shift_en_i) begin
            sdo_nxt = 1'b0;
            if (cnt_q < cnt_t'(DATA_W)) begin
              sr_sh = 1'b1;
              if (op_q == OP_READ) begin
                sr_sin  = 1'b0;
                sdo_nxt = sr_q[DATA_W-1];
              end
            end
`ifdef LDO_TEST_PARITY_EN
            else if (op_q == OP_READ) begin
              sdo_nxt = rd_par_q;
            end
`endif
            if (cnt_q == cnt_t'(LAST_IDX)) begin
              st_nxt = ST_DONE;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        default: begin
          sdo_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q        <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_NOP;
      sdo_q       <= 1'b0;
      busy_q      <= 1'b0;
      test_en_q   <= TEST_EN_RST;
      test_word_q <= '0;
      upd_q       <= 1'b0;
    end else begin
      st_q   <= st_nxt;
      sdo_q  <= sdo_nxt;
      busy_q <= (st_nxt != ST_IDLE);
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= sat_inc(cnt_q);
      end
      if (op_lat) begin
        op_q <= op_new;
      end
      // A mode write that leaves test_en unchanged is not announced to the LDO.
      upd_q <= wr_commit | (md_commit & (sr_q[0] ^ test_en_q));
      if (wr_commit) begin
        test_word_q <= sr_q;
      end
      if (md_commit) begin
        test_en_q <= sr_q[0];
      end
    end
  end

`ifdef LDO_TEST_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q    <= 1'b0;
      rd_par_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (st_q == ST_IDLE) begin
        par_q <= 1'b0;
      end else if (bit_take) begin
        par_q <= par_q ^ sp.sdi_i;
      end
      if (op_lat && (op_new == OP_READ)) begin
        rd_par_q <= ^code_i;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign err_o = err_q;
`endif

  assign sp.sdo_o    = sdo_q;
  assign sp.busy_o   = busy_q;
  assign test_en_o   = test_en_q;
  assign test_word_o = test_word_q;
  assign upd_o       = upd_q;

endmodule

// File: tb/tb_ldo_test_port.sv
// Self-checking bench for ldo_test_port; expected commits and readback bits go through a scoreboard queue.
// Parity scenarios are compiled in when LDO_TEST_PARITY_EN is defined.
module tb_ldo_test_port;
  import ldo_test_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] code;
  logic          test_en;
  logic [DW-1:0] word;
  logic          upd;
`ifdef LDO_TEST_PARITY_EN
  logic          err;
  logic          par_flip = 1'b0;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_word = '0;

  always #5 clk = ~clk;

  ldo_test_port_if sp();

  ldo_test_port #(.DATA_W(DW), .CMD_W(2), .TEST_EN_RST(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .sp          (sp),
    .code_i      (code),
    .test_en_o   (test_en),
    .test_word_o (word),
`ifdef LDO_TEST_PARITY_EN
    .err_o       (err),
`endif
    .upd_o       (upd)
  );

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    sp.sdi_i      = b;
    sp.shift_en_i = 1'b1;
    tick();
    sp.shift_en_i = 1'b0;
    sp.sdi_i      = 1'b0;
  endtask

  task automatic send_bits(input logic [DW-1:0] w, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      shift_bit(w[DW-1-i]);
      repeat (gap) tick();
    end
  endtask

  // Opens a frame, sends opcode and n data bits; a full frame also carries parity when enabled.
  task automatic do_frame(input logic [1:0] op, input logic [DW-1:0] w, input int n, input int gap);
    sp.frame_i = 1'b1;
    tick();
    shift_bit(op[1]);
    shift_bit(op[0]);
    send_bits(w, n, gap);
`ifdef LDO_TEST_PARITY_EN
    if (n == DW) shift_bit((^{op, w}) ^ par_flip);
`endif
  endtask

  task automatic end_frame();
    sp.frame_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int pulses;
    sp.frame_i = 1'b0; sp.shift_en_i = 1'b0; sp.sdi_i = 1'b0; code = '0;
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (word !== '0) begin errors++; $display("FAIL reset_word got %h want 0", word); end
    checks++; if (test_en !== 1'b0) begin errors++; $display("FAIL reset_test_en got %b want 0", test_en); end
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd got %b want 0", upd); end
    checks++; if (sp.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", sp.busy_o); end
    checks++; if (sp.sdo_o !== 1'b0) begin errors++; $display("FAIL reset_sdo got %b want 0", sp.sdo_o); end
`ifdef LDO_TEST_PARITY_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
`endif
    rst = 1'b1;
    tick();
    do_frame(OP_WRITE, 32'hFFFF_FFFF, 10, 0);
    checks++; if (sp.busy_o !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b want 1", sp.busy_o); end
    #2 rst = 1'b0;
    #1;
    checks++; if (sp.busy_o !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %b want 0", sp.busy_o); end
    checks++; if (word !== '0) begin errors++; $display("FAIL async_rst_word got %h want 0", word); end
    sp.frame_i = 1'b0;
    tick();
    rst = 1'b1;
    pulses = 0;
    repeat (4) begin
      tick();
      if (upd !== 1'b0) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rst_no_upd got %0d pulses want 0", pulses); end
  endtask

  task automatic test_write();
    logic [DW-1:0] e;
    exp_q.push_back(32'hDEAD_BEEF);
    do_frame(OP_WRITE, 32'hDEAD_BEEF, DW, 0);
    checks++; if (sp.busy_o !== 1'b1) begin errors++; $display("FAIL write_busy_done got %b want 1", sp.busy_o); end
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL write_early_upd got %b want 0", upd); end
    end_frame();
    checks++; if (upd !== 1'b1) begin errors++; $display("FAIL write_upd got %b want 1", upd); end
    e = exp_q.pop_front();
    model_word = e;
    checks++; if (word !== e) begin errors++; $display("FAIL write_word got %h want %h", word, e); end
    checks++; if (sp.busy_o !== 1'b0) begin errors++; $display("FAIL write_busy_end got %b want 0", sp.busy_o); end
    tick();
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL write_upd_width got %b want 0", upd); end
  endtask

  task automatic test_mode_read();
    logic [DW-1:0] e;
    logic [DW-1:0] rd;
    logic          b;
    exp_q.push_back(32'h1);
    do_frame(OP_MODE, 32'h0000_0001, DW, 0);
    end_frame();
    checks++; if (upd !== 1'b1) begin errors++; $display("FAIL mode_upd got %b want 1", upd); end
    e = exp_q.pop_front();
    checks++; if (test_en !== e[0]) begin errors++; $display("FAIL mode_en got %b want %b", test_en, e[0]); end
    tick();
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL mode_upd_width got %b want 0", upd); end
    do_frame(OP_MODE, 32'h0000_0001, DW, 0);
    end_frame();
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL mode_same_upd got %b want 0", upd); end
    checks++; if (test_en !== 1'b1) begin errors++; $display("FAIL mode_same_en got %b want 1", test_en); end
    tick();
    rd = 32'h0000_FFFF;
    code = 32'hFFFF_0000;
    sp.frame_i = 1'b1;
    tick();
    shift_bit(OP_READ[1]);
    code = rd;
    shift_bit(OP_READ[0]);
    code = 32'hA5A5_A5A5;
    for (int i = 0; i < DW; i++) exp_q.push_back({{(DW-1){1'b0}}, rd[DW-1-i]});
    for (int i = 0; i < DW; i++) begin
      b = 1'($urandom_range(0, 1));
      shift_bit(b);
      e = exp_q.pop_front();
      checks++; if (sp.sdo_o !== e[0]) begin errors++; $display("FAIL read_bit%0d got %b want %b", i, sp.sdo_o, e[0]); end
    end
`ifdef LDO_TEST_PARITY_EN
    shift_bit(1'b1);
    checks++; if (sp.sdo_o !== (^rd)) begin errors++; $display("FAIL read_par got %b want %b", sp.sdo_o, ^rd); end
`endif
    tick();
    checks++; if (sp.sdo_o !== 1'b0) begin errors++; $display("FAIL read_done_sdo got %b want 0", sp.sdo_o); end
    end_frame();
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL read_upd got %b want 0", upd); end
    checks++; if (word !== model_word) begin errors++; $display("FAIL read_word got %h want %h", word, model_word); end
  endtask

  task automatic test_abort();
    logic [DW-1:0] e;
    do_frame(OP_WRITE, 32'h0F0F_0F0F, 20, 0);
    end_frame();
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL abort_upd got %b want 0", upd); end
    checks++; if (word !== model_word) begin errors++; $display("FAIL abort_word got %h want %h", word, model_word); end
    checks++; if (sp.busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", sp.busy_o); end
    exp_q.push_back(32'h1234_5678);
    do_frame(OP_WRITE, 32'h1234_5678, DW, 0);
    end_frame();
    checks++; if (upd !== 1'b1) begin errors++; $display("FAIL abort_next_upd got %b want 1", upd); end
    e = exp_q.pop_front();
    model_word = e;
    checks++; if (word !== e) begin errors++; $display("FAIL abort_next_word got %h want %h", word, e); end
    tick();
  endtask

  task automatic test_overrun();
    logic [DW-1:0] e;
    int bad;
    exp_q.push_back(32'hCAFE_F00D);
    do_frame(OP_WRITE, 32'hCAFE_F00D, DW, 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      shift_bit(1'b1);
      tick();
      if (sp.sdo_o !== 1'b0 || sp.busy_o !== 1'b1 || upd !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL overrun_done got %0d bad cycles want 0", bad); end
    end_frame();
    checks++; if (upd !== 1'b1) begin errors++; $display("FAIL overrun_upd got %b want 1", upd); end
    e = exp_q.pop_front();
    model_word = e;
    checks++; if (word !== e) begin errors++; $display("FAIL overrun_word got %h want %h", word, e); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    exp_q.push_back(32'h0BAD_F00D);
    exp_q.push_back(32'h600D_CAFE);
    do_frame(OP_WRITE, 32'h0BAD_F00D, DW, 0);
    end_frame();
    e = exp_q.pop_front();
    checks++; if (upd !== 1'b1 || word !== e) begin errors++; $display("FAIL b2b_first got %h upd %b want %h upd 1", word, upd, e); end
    do_frame(OP_WRITE, 32'h600D_CAFE, DW, 0);
    end_frame();
    e = exp_q.pop_front();
    model_word = e;
    checks++; if (upd !== 1'b1 || word !== e) begin errors++; $display("FAIL b2b_second got %h upd %b want %h upd 1", word, upd, e); end
    tick();
  endtask

`ifdef LDO_TEST_PARITY_EN
  task automatic test_parity();
    par_flip = 1'b1;
    do_frame(OP_WRITE, 32'hA5A5_A5A5, DW, 0);
    par_flip = 1'b0;
    end_frame();
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL par_bad_upd got %b want 0", upd); end
    checks++; if (word !== model_word) begin errors++; $display("FAIL par_bad_word got %h want %h", word, model_word); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL par_bad_err got %b want 1", err); end
    tick();
    do_frame(OP_NOP, 32'h0, DW, 0);
    end_frame();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL par_nop_clr got %b want 0", err); end
    tick();
  endtask
`endif

  task automatic test_reset_mode();
    do_frame(OP_WRITE, 32'hFFFF_FFFF, 8, 0);
    #2 rst = 1'b0;
    #1;
    checks++; if (test_en !== 1'b0) begin errors++; $display("FAIL rst_mode_en got %b want 0", test_en); end
    sp.frame_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mode_read();
    test_abort();
    test_overrun();
    test_back_to_back();
`ifdef LDO_TEST_PARITY_EN
    test_parity();
`endif
    test_reset_mode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldo_test_port.md
Name: ldo_test_port

Overview:
- Serial test-access port that drives the digital LDO's 32-bit pass-gate test word and test-mode select.
- Captures the live pass-gate code from the controller for readback.
- Is the host-side writer/reader for the LDO test interface: it generates test_en/test_in and consumes the test_out code.
- Sits in the LDO clock domain, between the chip-level serial pins and the LDO top.

Parameters:
- DATA_W, 32, width of test word and captured code (one bit per pass transistor).
- CMD_W, 2, opcode width; fixed at 2 for the opcode set below.
- TEST_EN_RST, 0, reset value of test_en_o.

Ports:
- clk  in  1  LDO clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- frame_i  in  1  high for the duration of one serial transaction.
- shift_en_i  in  1  one serial bit is consumed/produced per clk cycle in which this is high while frame_i is high.
- sdi_i  in  1  serial data in, MSB first.
- sdo_o  out  1  serial data out, MSB first, registered.
- code_i  in  DATA_W  live pass-gate code from the LDO controller, same clock domain.
- test_en_o  out  1  selects test_word_o onto the pass gates.
- test_word_o  out  DATA_W  forced pass-gate code.
- upd_o  out  1  one-cycle pulse when test_word_o or test_en_o changes.
- busy_o  out  1  high while a frame is in progress.

Behaviour:
- Reset values:
  - test_en_o = TEST_EN_RST; test_word_o = 0; sdo_o = 0; upd_o = 0; busy_o = 0.
  - FSM = IDLE; bit counter = 0; shift register = 0.
- FSM states: IDLE, CMD, DATA, DONE.
- IDLE:
  - frame_i rising, i.e. frame_i=1 while in IDLE, goes to CMD.
  - busy_o=1 from the cycle after entry.
- CMD:
  - Shifts CMD_W bits from sdi_i on shift_en_i cycles.
  - After the 2nd bit, the opcode is latched and the FSM goes to DATA.
- DATA:
  - Shifts DATA_W bits.
  - After bit DATA_W the FSM goes to DONE.
  - Further shift_en_i pulses in DONE are ignored: no shift, sdo_o holds 0.
- Frame end: frame_i low in any state returns the FSM to IDLE next cycle with busy_o=0.
- Commit: only when frame_i falls in DONE, an opcode-specific commit occurs in that same cycle.
- Opcodes:
  - 00 NOP: no commit.
  - 01 WRITE: at commit, test_word_o <= shifted 32-bit word; upd_o=1 for one cycle.
  - 10 READ:
    - In the cycle the opcode is latched, code_i is sampled into the shift register.
    - During DATA, sdo_o presents bit DATA_W-1 on the first data shift, then successive bits MSB first. Each bit is updated on the cycle after the corresponding shift_en_i.
    - sdi_i is ignored. No commit.
  - 11 MODE: at commit, test_en_o <= data bit 0. upd_o pulses only if the value changes.
- Abort: frame_i low before DONE means no commit; test_word_o and test_en_o are unchanged; the partial word is discarded.
- shift_en_i with frame_i low: ignored.
- Back-to-back frames: frame_i may reassert the cycle after IDLE is re-entered. A reassertion in the same cycle as the commit is treated as a new frame starting next cycle.
- Reset mid-frame: all state is cleared immediately; test_en_o returns to TEST_EN_RST, so the LDO resumes closed-loop control.
- Counter width: clog2(DATA_W+1). No wrap: the counter saturates in DONE.

Optional Feature:
- Macro: LDO_TEST_PARITY_EN.
- Enabled:
  - One extra even-parity bit follows the data bits. It covers opcode and data, so DONE is reached after CMD_W+DATA_W+1 bits.
  - For WRITE and MODE, a parity mismatch suppresses the commit and sets the sticky output err_o.
  - err_o is cleared by reset or by a NOP frame with correct parity.
  - For READ, sdo_o outputs the even parity of the captured code as the final bit.
- Disabled: no parity bit; err_o is absent.

Decomposition:
- Package ldo_test_pkg:
  - Opcode constants OP_NOP/OP_WRITE/OP_READ/OP_MODE.
  - State enum.
  - Default DATA_W and CMD_W.
- Sub-module ldo_test_sreg:
  - Parallel-load, serial-in/serial-out shift register with width parameter.
  - Used once for the combined cmd/data path.

Test Plan:
- Reset: assert rst=0 mid-WRITE frame at bit 10 -> all outputs at reset values; test_word_o=0; no upd_o pulse.
- WRITE: send opcode 01 plus 0xDEADBEEF, then drop frame_i -> test_word_o=0xDEADBEEF in the commit cycle; upd_o high exactly 1 cycle; busy_o low the next cycle.
- MODE then READ:
  - MODE with data 0x00000001 -> test_en_o=1 with a single upd_o pulse.
  - READ with code_i=0x0000FFFF at opcode latch -> sdo_o streams 16 zeros then 16 ones.
  - Changing code_i mid-read does not alter the stream.
- Abort: WRITE frame with only 20 data bits, then frame_i low -> test_word_o keeps its previous value; no upd_o pulse; next full WRITE of 0x12345678 commits correctly.
- Overrun and gaps: WRITE with shift_en_i toggling every other cycle and 5 extra bits after DONE -> committed word equals the first 32 data bits; extras ignored.
- Parity (LDO_TEST_PARITY_EN): WRITE 0xA5A5A5A5 with a wrong parity bit -> no commit; err_o=1; a following NOP with correct parity clears err_o.
